// File: rtl/sat_pkg.sv
// Shared definitions for the saturating dot-product accumulator: FSM encoding and
// symmetric saturation bounds.
package sat_pkg;

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    // Largest positive value {0,1..1}, returned LSB-aligned in 32 bits.
    function automatic logic [31:0] sat_pos(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    // Most negative legal value {1,0..0,1}; the two's complement minimum is excluded.
    function automatic logic [31:0] sat_neg(input int unsigned w);
        return (32'd1 << (w - 1)) + 32'd1;
    endfunction

    // Illegal value {1,0..0}.
    function automatic logic [31:0] val_min(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/saturation_logic.sv
// Maps a raw W-bit add result onto the symmetric range, using carry to tell the
// direction of an overflow and folding the illegal minimum onto SAT_NEG.
module saturation_logic
    import sat_pkg::*;
#(
    parameter int unsigned WIDTH_SUM = 4
) (
    input  logic [WIDTH_SUM-1:0] sum,
    input  logic                 carry,
    input  logic                 oflow,
    output logic [WIDTH_SUM-1:0] result
);

    localparam logic [WIDTH_SUM-1:0] SAT_POS = WIDTH_SUM'(sat_pos(WIDTH_SUM));
    localparam logic [WIDTH_SUM-1:0] SAT_NEG = WIDTH_SUM'(sat_neg(WIDTH_SUM));
    localparam logic [WIDTH_SUM-1:0] VAL_MIN = WIDTH_SUM'(val_min(WIDTH_SUM));

    always_comb begin
        result = sum;
        // Overflow only happens with equal operand signs; carry set means both were negative.
        if (oflow) begin
            result = carry ? SAT_NEG : SAT_POS;
        end else if (sum == VAL_MIN) begin
            result = SAT_NEG;
        end
    end

endmodule

// File: rtl/sat_dot_accumulator.sv
// Sequential saturating dot-product accumulator: VEC_LEN products in over valid/ready,
// one saturated sum out over valid/ready.
module sat_dot_accumulator
    import sat_pkg::*;
#(
    parameter int unsigned WIDTH_SUM = 4,
    parameter int unsigned VEC_LEN   = 4,
    parameter int unsigned CNT_W     = 2
) (
    input  logic                 clk_80,
    input  logic                 reset_80,
    input  logic                 in_valid_80,
    output logic                 in_ready_80,
    input  logic [WIDTH_SUM-1:0] in_data_80,
    output logic                 out_valid_80,
    input  logic                 out_ready_80,
    output logic [WIDTH_SUM-1:0] out_data_80,
    output logic                 out_sat_80
);

    localparam logic [WIDTH_SUM-1:0] SAT_NEG = WIDTH_SUM'(sat_neg(WIDTH_SUM));
    localparam logic [WIDTH_SUM-1:0] VAL_MIN = WIDTH_SUM'(val_min(WIDTH_SUM));
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(VEC_LEN - 1);

    state_t               state_q, state_d;
    logic [WIDTH_SUM-1:0] acc_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 sat_q;

    logic [WIDTH_SUM-1:0] in_clamped, sum, acc_next;
    logic                 carry, oflow, sat_next;
    logic                 accept, out_fire, last;

    assign accept   = in_valid_80 & in_ready_80;
    assign out_fire = out_valid_80 & out_ready_80;
    assign last     = (cnt_q == CNT_LAST);

    assign in_clamped     = (in_data_80 == VAL_MIN) ? SAT_NEG : in_data_80;
    assign {carry, sum}   = {1'b0, acc_q} + {1'b0, in_clamped};
    assign oflow          = (acc_q[WIDTH_SUM-1] == in_clamped[WIDTH_SUM-1]) &
                            (sum[WIDTH_SUM-1] != acc_q[WIDTH_SUM-1]);
    assign sat_next       = sat_q | oflow | (sum == VAL_MIN);

    saturation_logic #(
        .WIDTH_SUM(WIDTH_SUM)
    ) u_sat (
        .sum   (sum),
        .carry (carry),
        .oflow (oflow),
        .result(acc_next)
    );

    always_ff @(posedge clk_80 or posedge reset_80) begin
        if (reset_80) state_q <= ACCUM;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM: if (accept && last) state_d = HOLD;
            HOLD:  if (out_fire)       state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_comb begin
        in_ready_80  = (state_q == ACCUM);
        out_valid_80 = (state_q == HOLD);
    end

    always_ff @(posedge clk_80 or posedge reset_80) begin
        if (reset_80) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_data_80 <= '0;
            out_sat_80  <= 1'b0;
        end else if (accept) begin
            acc_q <= acc_next;
            cnt_q <= cnt_q + CNT_W'(1);
            sat_q <= sat_next;
            if (last) begin
                out_data_80 <= acc_next;
                out_sat_80  <= sat_next;
            end
        end else if (out_fire) begin
            acc_q <= '0;
            cnt_q <= '0;
            sat_q <= 1'b0;
        end
    end

endmodule
